// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 keypad row scanner with whole-frame debounce, press encoding
// and a multi-digit hex entry buffer with optional backspace/clear editing.
module keypad_entry #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 2,
    parameter int DIGITS         = 4,
    parameter bit EDIT_KEYS      = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            i_col,
    output logic [3:0]            o_row,
    output logic [3:0]            o_key_code,
    output logic                  o_key_valid,
    output logic [4*DIGITS-1:0]   o_value,
    output logic [3:0]            o_count,
    output logic                  o_full
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int VW = 4 * DIGITS;
    localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);
    localparam logic [3:0] ND = 4'(DIGITS);

    typedef enum logic [1:0] {CLS_NONE, CLS_KEY, CLS_MULTI} cls_e;

    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    row_q, row_d;
    logic [15:0]   seen_q, seen_d;
    cls_e          prev_cls_q, prev_cls_d, acc_cls_q, acc_cls_d;
    logic [3:0]    prev_code_q, prev_code_d;
    logic [3:0]    stab_q, stab_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic [VW-1:0] value_q, value_d;
    logic [3:0]    count_q, count_d;

    logic          sample, frame_end, match;
    logic [15:0]   frame_bits;
    logic [4:0]    ones;
    logic [3:0]    frame_code;
    cls_e          frame_cls;

    always_comb begin
        sample     = dwell_q == DW'(SCAN_DIV - 1);
        frame_end  = sample && row_q == 2'd3;
        frame_bits = seen_q | ({12'b0, i_col} << {row_q, 2'b00});
        ones       = '0;
        frame_code = '0;
        for (int i = 0; i < 16; i++) begin
            ones = ones + 5'(frame_bits[i]);
            if (frame_bits[i]) frame_code = 4'(i);
        end
        frame_cls = ones == 5'd0 ? CLS_NONE : ones == 5'd1 ? CLS_KEY : CLS_MULTI;
        // codes only distinguish results when both frames are single-key
        match = frame_cls == prev_cls_q && (frame_cls != CLS_KEY || frame_code == prev_code_q);
        dwell_d     = sample ? '0 : dwell_q + 1'b1;
        row_d       = sample ? row_q + 2'd1 : row_q;
        seen_d      = !sample ? seen_q : frame_end ? '0 : frame_bits;
        prev_cls_d  = prev_cls_q;
        prev_code_d = prev_code_q;
        stab_d      = stab_q;
        acc_cls_d   = acc_cls_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        if (frame_end) begin
            prev_cls_d  = frame_cls;
            prev_code_d = frame_code;
            stab_d      = !match ? 4'd1 : stab_q >= DB ? stab_q : stab_q + 4'd1;
            if (stab_d == DB) begin
                acc_cls_d   = frame_cls;
                key_valid_d = acc_cls_q == CLS_NONE && frame_cls == CLS_KEY;
                key_code_d  = key_valid_d ? frame_code : key_code_q;
            end
        end
        value_d = value_q;
        count_d = count_q;
        if (key_valid_q) begin
            if (EDIT_KEYS && key_code_q == 4'hF) begin
                value_d = '0;
                count_d = '0;
            end else if (EDIT_KEYS && key_code_q == 4'hE) begin
                value_d = value_q >> 4;
                count_d = count_q == 4'd0 ? 4'd0 : count_q - 4'd1;
            end else if (count_q < ND) begin
                value_d = VW'({value_q, key_code_q});
                count_d = count_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell_q     <= '0;
            row_q       <= '0;
            seen_q      <= '0;
            prev_cls_q  <= CLS_NONE;
            prev_code_q <= '0;
            acc_cls_q   <= CLS_NONE;
            stab_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            value_q     <= '0;
            count_q     <= '0;
        end else begin
            dwell_q     <= dwell_d;
            row_q       <= row_d;
            seen_q      <= seen_d;
            prev_cls_q  <= prev_cls_d;
            prev_code_q <= prev_code_d;
            acc_cls_q   <= acc_cls_d;
            stab_q      <= stab_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            value_q     <= value_d;
            count_q     <= count_d;
        end
    end

    assign o_row       = 4'b0001 << row_q;
    assign o_key_code  = key_code_q;
    assign o_key_valid = key_valid_q;
    assign o_value     = value_q;
    assign o_count     = count_q;
    assign o_full      = count_q == ND;
endmodule
